// File: rtl/int_pkg.sv
// Shared constants, FSM encoding and vector-address helper for the interrupt controller.
package int_pkg;

  localparam int          NUM_IRQ    = 3;
  localparam logic [31:0] VEC_BASE   = 32'h0000_3024;
  localparam logic [31:0] VEC_STRIDE = 32'h0000_00A4;
  localparam int          ID_W       = $clog2(NUM_IRQ);
  localparam int          NL_W       = $clog2(NUM_IRQ + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic logic [31:0] vec_addr(input logic [ID_W-1:0] id);
    return VEC_BASE + 32'(id) * VEC_STRIDE;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder: index 0 has the highest priority.
module int_prio_enc #(
  parameter int W  = 3,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // first; that keeps the loop's last-write-wins order and avoids inferred latches.
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Nested priority interrupt controller: edge capture, arbitration against the
// in-service set, and a req/ack handshake towards the pipeline.
module int_ctrl
  import int_pkg::*;
(
  input  logic               clk,
  input  logic               clr_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               glb_en,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  output logic [31:0]        int_vec,
  input  logic               int_ack,
  input  logic               eret,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] in_service,
  output logic [NL_W-1:0]    nest_level
);

  logic [NUM_IRQ-1:0] sync1_q, sync1_d;
  logic [NUM_IRQ-1:0] sync2_q, sync2_d;
  logic [NUM_IRQ-1:0] edge_q, edge_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] in_service_q, in_service_d;
  state_e             state_q, state_d;
  logic               int_req_q, int_req_d;
  logic [ID_W-1:0]    int_id_q, int_id_d;
  logic [31:0]        int_vec_q, int_vec_d;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] ack_vec;
  logic [NUM_IRQ-1:0] eret_vec;
  logic [ID_W-1:0]    cand_idx, svc_idx;
  logic               cand_raw, svc_valid;
  logic               eligible;

  int_prio_enc #(.W(NUM_IRQ), .IW(ID_W)) u_cand_enc (
    .vec_i   (pending_q & ~irq_mask),
    .idx_o   (cand_idx),
    .valid_o (cand_raw)
  );

  int_prio_enc #(.W(NUM_IRQ), .IW(ID_W)) u_svc_enc (
    .vec_i   (in_service_q),
    .idx_o   (svc_idx),
    .valid_o (svc_valid)
  );

  // Only a strictly higher-priority source may preempt the innermost level.
  assign eligible = glb_en && cand_raw && (!svc_valid || (cand_idx < svc_idx));

  always_comb begin
    sync1_d = irq;
    sync2_d = sync1_q;
    edge_d  = sync2_q;
    rise    = sync2_q & ~edge_q;
  end

  always_comb begin
    state_d   = state_q;
    int_req_d = int_req_q;
    int_id_d  = int_id_q;
    int_vec_d = int_vec_q;
    ack_vec   = '0;

    unique case (state_q)
      IDLE: begin
        if (eligible) begin
          state_d   = REQ;
          int_req_d = 1'b1;
          int_id_d  = cand_idx;
          int_vec_d = vec_addr(cand_idx);
        end
      end
      REQ: begin
        if (int_ack) begin
          ack_vec   = NUM_IRQ'(1) << int_id_q;
          int_req_d = 1'b0;
          state_d   = HOLD;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // eret retires the innermost level seen before this cycle's ack is applied.
    eret_vec     = (eret && svc_valid) ? (NUM_IRQ'(1) << svc_idx) : '0;
    in_service_d = (in_service_q & ~eret_vec) | ack_vec;
    pending_d    = (pending_q & ~ack_vec) | rise;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      edge_q       <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      state_q      <= IDLE;
      int_req_q    <= 1'b0;
      int_id_q     <= '0;
      int_vec_q    <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      edge_q       <= edge_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      state_q      <= state_d;
      int_req_q    <= int_req_d;
      int_id_q     <= int_id_d;
      int_vec_q    <= int_vec_d;
    end
  end

  always_comb begin
    nest_level = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      nest_level = nest_level + NL_W'(in_service_q[i]);
    end
  end

  assign int_req    = int_req_q;
  assign int_id     = int_id_q;
  assign int_vec    = int_vec_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule
